// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: RegDst select codes
// and fixed register indices.
package mips_pkg;

  localparam int RD_RT = 0;
  localparam int RD_RA = 1;
  localparam int RD_SP = 2;
  localparam int RD_RD = 3;
  localparam int RD_RS = 4;

  localparam int REG_RA   = 31;
  localparam int REG_SP   = 29;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/reg_dst_wb_queue_if.sv
// Write-back queue bus: request side (in_*, ir_*, reg_dst)
// and register-file drain side (wb_*), plus status.
interface reg_dst_wb_queue_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  reg_dst;
  logic [ADDR_W-1:0] ir_rt;
  logic [ADDR_W-1:0] ir_rd;
  logic [ADDR_W-1:0] ir_rs;
  logic [DATA_W-1:0] in_data;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  count;
  logic              illegal_sel;

  modport master (
    output in_valid, reg_dst, ir_rt, ir_rd,
    output ir_rs, in_data, wb_ready,
    input  in_ready, wb_valid, wb_addr,
    input  wb_data, count, illegal_sel
  );

  modport slave (
    input  in_valid, reg_dst, ir_rt, ir_rd,
    input  ir_rs, in_data, wb_ready,
    output in_ready, wb_valid, wb_addr,
    output wb_data, count, illegal_sel
  );

endinterface

// File: rtl/reg_dst_decode.sv
// Combinational RegDst decoder.
// Ports: i_sel/i_rt/i_rd/i_rs in; o_idx, o_illegal out.
module reg_dst_decode
  import mips_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 3,
  parameter int RA_IDX = REG_RA,
  parameter int SP_IDX = REG_SP
) (
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [ADDR_W-1:0] i_rt,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [ADDR_W-1:0] i_rs,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_illegal
);

  always_comb begin
    o_idx     = '0;
    o_illegal = 1'b0;
    unique case (1'b1)
      (i_sel == SEL_W'(RD_RT)): o_idx = i_rt;
      (i_sel == SEL_W'(RD_RA)): o_idx = ADDR_W'(RA_IDX);
      (i_sel == SEL_W'(RD_SP)): o_idx = ADDR_W'(SP_IDX);
      (i_sel == SEL_W'(RD_RD)): o_idx = i_rd;
      (i_sel == SEL_W'(RD_RS)): o_idx = i_rs;
      default:                  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_dst_wb_queue.sv
// Decoded register write-back FIFO feeding the register file.
// Ports: clk, rst_n, flush, bus (slave: request + drain side).
module reg_dst_wb_queue
  import mips_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 4,
  parameter int RA_IDX = REG_RA,
  parameter int SP_IDX = REG_SP
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  reg_dst_wb_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ill;

  logic [ADDR_W-1:0] w_idx;
  logic              w_ill;
  logic              w_full;
  logic              w_empty;
  logic              w_acc;
  logic              w_push;
  logic              w_pop;

  reg_dst_decode #(
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W),
    .RA_IDX (RA_IDX),
    .SP_IDX (SP_IDX)
  ) u_dec (
    .i_sel     (bus.reg_dst),
    .i_rt      (bus.ir_rt),
    .i_rd      (bus.ir_rd),
    .i_rs      (bus.ir_rs),
    .o_idx     (w_idx),
    .o_illegal (w_ill)
  );

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // $zero and illegal requests handshake but never store
  assign w_acc  = bus.in_valid && !w_full && !flush;
  assign w_push = w_acc && !w_ill && (w_idx != '0);
  assign w_pop  = !w_empty && bus.wb_ready && !flush;

  assign bus.in_ready    = !w_full;
  assign bus.wb_valid    = !w_empty;
  assign bus.wb_addr     = w_empty ? '0 : r_addr[r_rptr];
  assign bus.wb_data     = w_empty ? '0 : r_data[r_rptr];
  assign bus.count       = r_count;
  assign bus.illegal_sel = r_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ill   <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ill   <= 1'b0;
    end else begin
      if (w_push) begin
        r_addr[r_wptr] <= w_idx;
        r_data[r_wptr] <= bus.in_data;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CNT_W'(1);
      if (w_acc && w_ill)
        r_ill <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_dst_wb_queue.sv
// Self-checking bench for reg_dst_wb_queue: vector table
// plus scoreboard model, then flush and reset sequences.
module tb_reg_dst_wb_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [31:0] data;
    logic        wr;
    int          exp_cnt;
    logic        exp_rdy;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  ent_t sb[$];
  logic m_ill = 1'b0;

  vec_t tbl[21];

  reg_dst_wb_queue_if #(
    .ADDR_W (5), .DATA_W (32),
    .SEL_W  (3), .DEPTH  (DEPTH)
  ) bus ();

  reg_dst_wb_queue #(
    .ADDR_W (5), .DATA_W (32),
    .SEL_W  (3), .DEPTH  (DEPTH),
    .RA_IDX (31), .SP_IDX (29)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic v, input logic [2:0] sel,
      input logic [4:0] rt, input logic [31:0] d,
      input logic wr, input int cnt, input logic rdy);
    vec_t t;
    t.v = v; t.sel = sel; t.rt = rt;
    t.rd = 5'd12; t.rs = 5'd5; t.data = d;
    t.wr = wr; t.exp_cnt = cnt; t.exp_rdy = rdy;
    return t;
  endfunction

  function automatic logic [5:0] ref_dec(
      input logic [2:0] s, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] rs);
    // {illegal, index}
    case (s)
      3'd0: return {1'b0, rt};
      3'd1: return {1'b0, 5'd31};
      3'd2: return {1'b0, 5'd29};
      3'd3: return {1'b0, rd};
      3'd4: return {1'b0, rs};
      default: return 6'b100000;
    endcase
  endfunction

  // one clock: drive, check at negedge, advance model
  task automatic step(input vec_t t, input logic fl);
    logic [5:0] d;
    logic acc, pop;
    ent_t e;
    bus.in_valid = t.v;
    bus.reg_dst  = t.sel;
    bus.ir_rt    = t.rt;
    bus.ir_rd    = t.rd;
    bus.ir_rs    = t.rs;
    bus.in_data  = t.data;
    bus.wb_ready = t.wr;
    flush        = fl;
    @(negedge clk);
    chk("count", 64'(bus.count), 64'(sb.size()));
    chk("in_ready", 64'(bus.in_ready),
        64'(sb.size() < DEPTH));
    chk("wb_valid", 64'(bus.wb_valid),
        64'(sb.size() != 0));
    chk("illegal_sel", 64'(bus.illegal_sel),
        64'(m_ill));
    if (t.exp_cnt >= 0) begin
      chk("tbl_count", 64'(bus.count),
          64'(t.exp_cnt));
      chk("tbl_ready", 64'(bus.in_ready),
          64'(t.exp_rdy));
    end
    if (sb.size() != 0) begin
      chk("wb_addr", 64'(bus.wb_addr),
          64'(sb[0].addr));
      chk("wb_data", 64'(bus.wb_data),
          64'(sb[0].data));
    end
    d   = ref_dec(t.sel, t.rt, t.rd, t.rs);
    acc = t.v && (sb.size() < DEPTH) && !fl;
    pop = (sb.size() != 0) && t.wr && !fl;
    if (fl) begin
      sb.delete();
      m_ill = 1'b0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (acc && d[5]) m_ill = 1'b1;
      if (acc && !d[5] && d[4:0] != 5'd0) begin
        e.addr = d[4:0];
        e.data = t.data;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 8, 32'hDEADBEEF, 1, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 1, 1, 1);
    tbl[2]  = mk(0, 0, 0, 0, 1, 0, 1);
    tbl[3]  = mk(1, 1, 0, 32'h1, 0, 0, 1);
    tbl[4]  = mk(1, 2, 0, 32'h2, 0, 1, 1);
    tbl[5]  = mk(1, 3, 0, 32'h3, 0, 2, 1);
    tbl[6]  = mk(1, 4, 0, 32'h4, 0, 3, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 4, 0);
    tbl[8]  = mk(1, 0, 9, 32'h5, 1, 4, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 3, 1);
    tbl[10] = mk(1, 0, 10, 32'hA, 1, 2, 1);
    tbl[11] = mk(1, 0, 11, 32'hB, 1, 2, 1);
    tbl[12] = mk(1, 0, 13, 32'hC, 1, 2, 1);
    tbl[13] = mk(1, 0, 14, 32'hD, 1, 2, 1);
    tbl[14] = mk(1, 0, 15, 32'hE, 1, 2, 1);
    tbl[15] = mk(1, 0, 16, 32'hF, 1, 2, 1);
    tbl[16] = mk(0, 0, 0, 0, 1, 2, 1);
    tbl[17] = mk(0, 0, 0, 0, 1, 1, 1);
    tbl[18] = mk(1, 6, 0, 32'h66, 1, 0, 1);
    tbl[19] = mk(1, 0, 0, 32'h77, 1, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 1, 0, 1);

    bus.in_valid = 1'b0;
    bus.reg_dst  = '0;
    bus.ir_rt    = '0;
    bus.ir_rd    = '0;
    bus.ir_rs    = '0;
    bus.in_data  = '0;
    bus.wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_count", 64'(bus.count), 0);
    chk("rst_valid", 64'(bus.wb_valid), 0);
    chk("rst_addr", 64'(bus.wb_addr), 0);
    chk("rst_data", 64'(bus.wb_data), 0);
    chk("rst_ill", 64'(bus.illegal_sel), 0);
    chk("rst_ready", 64'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++)
      step(tbl[i], 1'b0);
    chk("ill_sticky", 64'(bus.illegal_sel), 1);

    // flush with three queued and illegal_sel set
    step(mk(1, 0, 3, 32'h100, 0, 0, 1), 1'b0);
    step(mk(1, 0, 4, 32'h101, 0, 1, 1), 1'b0);
    step(mk(1, 3, 0, 32'h102, 0, 2, 1), 1'b0);
    step(mk(1, 0, 7, 32'h103, 1, 3, 1), 1'b1);
    chk("flush_count", 64'(bus.count), 0);
    chk("flush_valid", 64'(bus.wb_valid), 0);
    chk("flush_ill", 64'(bus.illegal_sel), 0);
    step(mk(0, 0, 0, 0, 1, 0, 1), 1'b0);

    // asynchronous reset in the middle of a drain
    step(mk(1, 0, 20, 32'h200, 0, 0, 1), 1'b0);
    step(mk(1, 0, 21, 32'h201, 0, 1, 1), 1'b0);
    step(mk(0, 0, 0, 0, 1, 2, 1), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(bus.count), 0);
    chk("arst_valid", 64'(bus.wb_valid), 0);
    chk("arst_addr", 64'(bus.wb_addr), 0);
    chk("arst_data", 64'(bus.wb_data), 0);
    sb.delete();
    m_ill = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(mk(1, 4, 0, 32'h300, 1, 0, 1), 1'b0);
    step(mk(0, 0, 0, 0, 1, 1, 1), 1'b0);
    step(mk(0, 0, 0, 0, 1, 0, 1), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reg_dst_wb_queue.md
Name: reg_dst_wb_queue

Overview:
- Parametrised successor to the register-destination select mux in the multicycle MIPS datapath.
- Decodes the RegDst code against the rt, rd and rs fields and the fixed $ra/$sp indices.
- Pairs the decoded index with write-back data and buffers pairs in a small FIFO.
- Drains the FIFO to the register-file write port over a valid/ready handshake, so the control FSM can issue write-backs without stalling on the register file.
- Filters $zero writes and flags illegal select codes.

Parameters:
- ADDR_W, 5: register index width.
- DATA_W, 32: write-back data width.
- SEL_W, 3: RegDst code width.
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.
- RA_IDX, 31: index for code 1 (link register).
- SP_IDX, 29: index for code 2 (stack pointer).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  write-back request present.
- in_ready  out  1  queue can accept; equals !full.
- reg_dst  in  SEL_W  destination select code.
- ir_rt  in  ADDR_W  IR[20:16].
- ir_rd  in  ADDR_W  IR[15:11].
- ir_rs  in  ADDR_W  IR[25:21].
- in_data  in  DATA_W  write-back value.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  register file accepts head.
- wb_addr  out  ADDR_W  head destination index.
- wb_data  out  DATA_W  head data.
- count  out  $clog2(DEPTH+1)  occupancy.
- illegal_sel  out  1  sticky: an illegal code was accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, rst_n.
- Reset values:
  - count=0, wb_valid=0, wb_addr=0, wb_data=0.
  - illegal_sel=0; read/write pointers=0.
  - in_ready=1 once reset is released.
- Decode (combinational on the input side):
  - 0 -> ir_rt
  - 1 -> RA_IDX
  - 2 -> SP_IDX
  - 3 -> ir_rd
  - 4 -> ir_rs
  - 5..7 -> illegal
- Accept occurs when in_valid && in_ready && !flush. On accept:
  - Legal code, decoded index != 0: enqueue {index, in_data}.
  - Legal code, decoded index == 0: discard; count unchanged; illegal_sel unchanged.
  - Illegal code: discard; set illegal_sel=1.
- Illegal and $zero requests still complete the handshake; in_ready does not depend on the code.
- Dequeue occurs when wb_valid && wb_ready. Head advances on the next edge.
- Output timing:
  - wb_addr and wb_data show the head entry while wb_valid=1.
  - wb_valid rises one cycle after an enqueue into an empty queue. There is no combinational in-to-out bypass.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. When full, in_ready=0 regardless of wb_ready; there is no pass-through when full.
- Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- flush=1, effective on the next edge:
  - count=0, pointers=0, wb_valid=0.
  - illegal_sel cleared.
  - Any same-cycle in_valid is dropped.
  - Any same-cycle dequeue is ignored (the entry is already discarded).
- wb_valid and head data stay stable while wb_ready=0. Data cannot change under a stalled handshake.
- Reset asserted mid-operation: all state clears immediately (asynchronously); queued writes are lost.
- Width rules:
  - Index outputs are exactly ADDR_W bits; no truncation from wider constants.
  - RA_IDX and SP_IDX must each be < 2**ADDR_W.

Decomposition:
- Shared package (mips_pkg):
  - RegDst code localparams: RD_RT=0, RD_RA=1, RD_SP=2, RD_RD=3, RD_RS=4.
  - Default register indices REG_RA=31, REG_SP=29, REG_ZERO=0.
- Sub-module reg_dst_decode: purely combinational decoder, outputs index and illegal flag. It replaces the old select mux in other datapath users.
- The FIFO storage and pointers stay inline in reg_dst_wb_queue.

Test Plan:
1. Reset, then in_valid with reg_dst=0, ir_rt=8, in_data=0xDEADBEEF, wb_ready=1 -> next cycle wb_valid=1, wb_addr=8, wb_data=0xDEADBEEF; following cycle wb_valid=0, count=0.
2. Codes 1,2,3,4 with ir_rd=12, ir_rs=5, wb_ready=0 -> count=4, in_ready=0; then wb_ready=1 drains in order: addr 31, 29, 12, 5.
3. reg_dst=6 -> illegal_sel=1, count=0, in_ready stays 1. reg_dst=0 with ir_rt=0 -> discarded, illegal_sel stays 1, count=0.
4. Full queue (count=4) with wb_ready=1 and in_valid=1 in the same cycle -> in_ready=0; the push is not taken; count=3 next cycle.
5. Queue holding 2 entries: simultaneous push and pop across a pointer wrap (6 mixed operations) -> FIFO order preserved, count constant at 2.
6. Queue holding 3 entries plus illegal_sel=1: assert flush with in_valid=1 -> next cycle count=0, wb_valid=0, illegal_sel=0. Separately, pulse rst_n low mid-drain -> outputs clear immediately.
